// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with done/enable release and a MAX_HOLD forced-release timeout.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_idx_o,
  output logic       busy_o,
  output logic       timeout_o
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [2:0] ptr_q, ptr_d, idx_q, idx_d, sel;
  logic [3:0] cnt_q, cnt_d;
  logic       to_q, to_d, hold_end, exit_g;
  // descending scan so the lowest offset from ptr wins
  always_comb begin
    sel = ptr_q;
    for (int i = 7; i >= 0; i--)
      if (req_i[ptr_q + 3'(i)]) sel = ptr_q + 3'(i);
  end
  assign hold_end = cnt_q == 4'(MAX_HOLD - 1);
  assign exit_g   = done_i | ~req_i[idx_q] | ~en_i | hold_end;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: if (en_i && |req_i) begin
        state_d = GRANT;
        idx_d   = sel;
        cnt_d   = '0;
      end
      GRANT: begin
        state_d = exit_g ? RELEASE : GRANT;
        cnt_d   = exit_g ? 4'd0 : cnt_q + 4'd1;
        to_d    = hold_end & ~done_i & req_i[idx_q] & en_i;
      end
      RELEASE: begin
        state_d = IDLE;
        ptr_d   = idx_q + 3'd1;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
  assign busy_o    = state_q == GRANT;
  assign gnt_o     = busy_o ? 8'b1 << idx_q : 8'b0;
  assign gnt_idx_o = idx_q;
  assign timeout_o = to_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed checks of rr_arbiter8 (MAX_HOLD=4 instance plus a default-parameter instance).
module tb_rr_arbiter8;
  logic       clk, rst, en, done;
  logic [7:0] req, req2;
  logic [7:0] gnt, gnt2;
  logic [2:0] idx, idx2;
  logic       busy, busy2, to, to2;
  int passed = 0, total = 0;

  rr_arbiter8 #(.MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .en_i(en), .req_i(req), .done_i(done),
    .gnt_o(gnt), .gnt_idx_o(idx), .busy_o(busy), .timeout_o(to)
  );
  rr_arbiter8 u_dut15 (
    .clk(clk), .rst(rst), .en_i(1'b1), .req_i(req2), .done_i(1'b0),
    .gnt_o(gnt2), .gnt_idx_o(idx2), .busy_o(busy2), .timeout_o(to2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; req = 8'h00; req2 = 8'h00; done = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_idx", idx, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_to", to, 1'b0);
    tick(); tick();
    rst = 1'b0;
    // single request, done three cycles after grant
    en = 1'b1; req = 8'h10;
    tick();
    chk("single_gnt", gnt, 8'h10);
    chk("single_idx", idx, 3'd4);
    chk("single_busy", busy, 1'b1);
    tick(); tick();
    chk("single_hold", gnt, 8'h10);
    done = 1'b1;
    tick();
    chk("single_rel_gnt", gnt, 8'h00);
    chk("single_rel_busy", busy, 1'b0);
    chk("single_rel_to", to, 1'b0);
    chk("single_rel_idx", idx, 3'd4);
    done = 1'b0; req = 8'h21;
    tick();
    chk("single_idle_gnt", gnt, 8'h00);
    tick();
    chk("ptr5_gnt", gnt, 8'h20);
    chk("ptr5_idx", idx, 3'd5);
    // asynchronous reset mid-grant
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gnt", gnt, 8'h00);
    chk("async_rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", gnt, 8'h01);
    req = 8'h00;
    tick();
    chk("reqdrop_rel_gnt", gnt, 8'h00);
    chk("reqdrop_rel_to", to, 1'b0);
    // round-robin with wrap
    rst = 1'b1;
    #1 rst = 1'b0;
    req = 8'hFF; done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("rr_gnt%0d", k), gnt, 8'h01 << (k % 8));
      tick();
      chk($sformatf("rr_rel%0d", k), gnt, 8'h00);
      if (k < 8) begin
        tick();
        chk($sformatf("rr_idle%0d", k), gnt, 8'h00);
      end
    end
    req = 8'h00; done = 1'b0;
    tick();
    // MAX_HOLD timeout
    req = 8'h04;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("to_hold%0d", k), gnt, 8'h04);
      chk($sformatf("to_low%0d", k), to, 1'b0);
    end
    tick();
    chk("to_rel_gnt", gnt, 8'h00);
    chk("to_pulse", to, 1'b1);
    tick();
    chk("to_idle_to", to, 1'b0);
    chk("to_idle_gnt", gnt, 8'h00);
    tick();
    chk("to_regrant", gnt, 8'h04);
    // done coinciding with the last hold cycle
    tick(); tick(); tick();
    done = 1'b1;
    tick();
    chk("simul_gnt", gnt, 8'h00);
    chk("simul_to", to, 1'b0);
    done = 1'b0;
    // enable gating
    rst = 1'b1;
    #1 rst = 1'b0;
    en = 1'b0; req = 8'h81;
    tick(); tick(); tick();
    chk("en_off_gnt", gnt, 8'h00);
    en = 1'b1;
    tick();
    chk("en_on_gnt", gnt, 8'h01);
    en = 1'b0;
    tick();
    chk("en_drop_gnt", gnt, 8'h00);
    chk("en_drop_to", to, 1'b0);
    // line 3 drops its request while granted
    en = 1'b1; req = 8'h08;
    tick(); tick();
    chk("l3_gnt", gnt, 8'h08);
    chk("l3_idx", idx, 3'd3);
    req = 8'h00;
    tick();
    chk("l3_rel_gnt", gnt, 8'h00);
    chk("l3_rel_to", to, 1'b0);
    req = 8'h11;
    tick(); tick();
    chk("ptr4_gnt", gnt, 8'h10);
    req = 8'h13;
    tick();
    chk("other_req_gnt", gnt, 8'h10);
    chk("other_req_idx", idx, 3'd4);
    // default MAX_HOLD of 15
    req2 = 8'h80;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("d15_hold%0d", k), gnt2, 8'h80);
    end
    tick();
    chk("d15_rel_gnt", gnt2, 8'h00);
    chk("d15_to", to2, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
